word_serial_tx: RTL and testbench
=================================

Name: word_serial_tx

Overview:
- Parallel-to-serial transmitter for 16-bit datapath words.
- Accepts one word over a valid/ready handshake and shifts it onto a single-bit line as a framed word: start, data, optional even parity, stop.
- Optional bitwise inversion of the data before shifting, for links that carry complemented data.
- Its counterpart is a word deserializer on the receiving end of the same line.

Parameters:
- WIDTH, 16, data word width in bits (2..32).
- BIT_CYCLES, 1, clock cycles each line bit is held (1..255).
- LSB_FIRST, 1, 1 = bit 0 sent first; 0 = bit WIDTH-1 sent first.
- PARITY_EN, 1, 1 = insert even-parity bit after the data bits; 0 = no parity bit.
- INVERT, 0, 1 = complement the captured word before serialization.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_data  input  WIDTH  word to transmit; sampled only on accept.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  transmitter can accept a word this cycle.
- ser_out  output  1  serial line; idle level 1.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse after a frame's stop bit completes.

Behaviour:
Reset (rst_n=0, asynchronous):
- ser_out=1, in_ready=0, busy=0, done=0; state=IDLE; counters cleared.
- In IDLE after release, in_ready=1.

Accept:
- Occurs on a rising edge with in_valid=1 and in_ready=1.
- Capture shift_reg = INVERT ? ~in_data : in_data.
- Compute parity = XOR of the captured (post-inversion) bits.
- in_ready is 1 only in IDLE.

State machine (states IDLE, START, DATA, PARITY, STOP):
- IDLE: ser_out=1, busy=0. On accept go to START.
- START: ser_out=0 for BIT_CYCLES clocks, then DATA.
- DATA: WIDTH bits, each held BIT_CYCLES clocks, order per LSB_FIRST. After the last bit go to PARITY if PARITY_EN, else STOP.
- PARITY: ser_out=parity for BIT_CYCLES clocks, then STOP.
- STOP: ser_out=1 for BIT_CYCLES clocks, then IDLE with done=1 for exactly that first IDLE cycle.

Timing:
- ser_out, busy and done are registered.
- The start bit appears in the cycle after the accept edge.
- busy=1 from the first start cycle through the last stop cycle.
- Frame length = (2 + WIDTH + PARITY_EN) * BIT_CYCLES cycles.
- Minimum spacing between accepts = frame length + 1 (one IDLE cycle, ser_out=1).

Counters:
- Bit-time counter counts 0..BIT_CYCLES-1 and wraps at each bit boundary.
- Bit-index counter counts 0..WIDTH-1 and is used only in DATA.

Boundary conditions:
- in_data/in_valid changes mid-frame have no effect on the current frame.
- in_valid held high through a frame: next word accepted in the IDLE cycle after STOP, the same cycle done=1.
- Reset mid-frame: frame aborted immediately; ser_out=1; no done pulse; no word pending after release.
- in_valid=0 in IDLE: remain IDLE indefinitely, ser_out=1.

Test Plan:
- Defaults (WIDTH=16, BIT_CYCLES=1, LSB_FIRST=1, PARITY_EN=1, INVERT=0), reset then release -> ser_out=1, busy=0, done=0, in_ready=1 on first edge after release.
- Defaults, accept 16'h00FF at edge E0 -> cycles E0+1..E0+19 show: start 0; 1 x8; 0 x8; parity 0; stop 1. busy=1 over those 19 cycles. At E0+20: done=1, in_ready=1.
- Defaults, in_valid held with 16'h0001 during an active frame, in_data changed to 16'hFFFF mid-frame -> first frame bits unchanged. Next word (value present at the IDLE cycle) is accepted only when in_ready=1, exactly 20 cycles after the prior accept.
- INVERT=1, accept 16'h0000 -> data bits all 1, parity 0. LSB_FIRST=0 with 16'h8000, INVERT=0 -> first data bit 1, then fifteen 0s, parity 1.
- Defaults, rst_n pulsed low during data bit 5 of a frame -> ser_out=1 asynchronously, busy=0, in_ready=0 while low. After release: in_ready=1, no done pulse.
- BIT_CYCLES=3, accept 16'h0001 -> each bit held 3 clocks, frame 57 cycles, parity bit 1, done exactly at cycle 58 after the accept edge.

Source files
------------

// File: rtl/word_serial_tx.sv
// Framed parallel-to-serial transmitter: start, data, optional even parity, stop.
// Line outputs are registered from next-state values so the start bit follows the accept edge.
module word_serial_tx #(
  parameter int WIDTH      = 16,
  parameter int BIT_CYCLES = 1,
  parameter int LSB_FIRST  = 1,
  parameter int PARITY_EN  = 1,
  parameter int INVERT     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam int TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           r_state, w_next_state;
  logic [TW-1:0]    r_tcnt;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_shift, w_shift_next, w_capture;
  logic             r_parity, w_parity_next;
  logic             r_ser, r_busy, r_done, r_ready;
  logic             w_accept, w_bit_end, w_last_bit, w_ser_next;

  assign w_accept   = in_valid & r_ready;
  assign w_bit_end  = (r_tcnt == TW'(BIT_CYCLES - 1));
  assign w_last_bit = (r_idx == IW'(WIDTH - 1));
  assign w_capture  = (INVERT != 0) ? ~in_data : in_data;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = START;
      START:   if (w_bit_end) w_next_state = DATA;
      DATA:    if (w_bit_end && w_last_bit) w_next_state = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (w_bit_end) w_next_state = STOP;
      STOP:    if (w_bit_end) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_shift_next  = r_shift;
    w_parity_next = r_parity;
    if (w_accept) begin
      w_shift_next  = w_capture;
      w_parity_next = ^w_capture;
    end else if (r_state == DATA && w_bit_end) begin
      w_shift_next = (LSB_FIRST != 0) ? (r_shift >> 1) : (r_shift << 1);
    end
  end

  // The line level for the coming cycle is derived from the state being entered.
  always_comb begin
    w_ser_next = 1'b1;
    case (w_next_state)
      START:   w_ser_next = 1'b0;
      DATA:    w_ser_next = (LSB_FIRST != 0) ? w_shift_next[0] : w_shift_next[WIDTH-1];
      PARITY:  w_ser_next = w_parity_next;
      default: w_ser_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_tcnt   <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_ser    <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_tcnt   <= (r_state == IDLE || w_bit_end) ? '0 : r_tcnt + TW'(1);
      if (r_state == DATA && w_bit_end)
        r_idx <= w_last_bit ? '0 : r_idx + IW'(1);
      else if (r_state != DATA)
        r_idx <= '0;
      r_shift  <= w_shift_next;
      r_parity <= w_parity_next;
      r_ser    <= w_ser_next;
      r_busy   <= (w_next_state != IDLE);
      r_done   <= (r_state == STOP) && (w_next_state == IDLE);
      r_ready  <= (w_next_state == IDLE);
    end
  end

  assign in_ready = r_ready;
  assign ser_out  = r_ser;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_word_serial_tx.sv
// Bench for word_serial_tx: five parameter variants, per-cycle expected line values
// queued at each accept and compared on the falling edge.
module tb_word_serial_tx;

  localparam int N = 5;
  localparam int BC_A  [N] = '{1, 1, 1, 3, 2};
  localparam int LSB_A [N] = '{1, 1, 0, 1, 1};
  localparam int INV_A [N] = '{0, 1, 0, 0, 0};
  localparam int PE_A  [N] = '{1, 1, 1, 1, 0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] din [N];
  logic        vin [N];
  logic        rdy [N];
  logic        ser [N];
  logic        bsy [N];
  logic        dn  [N];

  typedef struct { logic ser; logic busy; logic done; logic rdy; } exp_t;
  typedef struct { int cfg; logic [15:0] data; logic par; } vec_t;

  exp_t exp_q [$];
  vec_t vt [9];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cur      = 0;

  always #5 clk = ~clk;

  word_serial_tx #(.WIDTH(16), .BIT_CYCLES(1), .LSB_FIRST(1), .PARITY_EN(1), .INVERT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(din[0]), .in_valid(vin[0]),
    .in_ready(rdy[0]), .ser_out(ser[0]), .busy(bsy[0]), .done(dn[0]));
  word_serial_tx #(.WIDTH(16), .BIT_CYCLES(1), .LSB_FIRST(1), .PARITY_EN(1), .INVERT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(din[1]), .in_valid(vin[1]),
    .in_ready(rdy[1]), .ser_out(ser[1]), .busy(bsy[1]), .done(dn[1]));
  word_serial_tx #(.WIDTH(16), .BIT_CYCLES(1), .LSB_FIRST(0), .PARITY_EN(1), .INVERT(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(din[2]), .in_valid(vin[2]),
    .in_ready(rdy[2]), .ser_out(ser[2]), .busy(bsy[2]), .done(dn[2]));
  word_serial_tx #(.WIDTH(16), .BIT_CYCLES(3), .LSB_FIRST(1), .PARITY_EN(1), .INVERT(0)) u3 (
    .clk(clk), .rst_n(rst_n), .in_data(din[3]), .in_valid(vin[3]),
    .in_ready(rdy[3]), .ser_out(ser[3]), .busy(bsy[3]), .done(dn[3]));
  word_serial_tx #(.WIDTH(16), .BIT_CYCLES(2), .LSB_FIRST(1), .PARITY_EN(0), .INVERT(0)) u4 (
    .clk(clk), .rst_n(rst_n), .in_data(din[4]), .in_valid(vin[4]),
    .in_ready(rdy[4]), .ser_out(ser[4]), .busy(bsy[4]), .done(dn[4]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cfg %0d, t=%0t): got %0h, expected %0h", name, cur, $time, act, exp);
    end
  endtask

  task automatic push_bit(input int k, input logic b);
    repeat (BC_A[k]) exp_q.push_back('{b, 1'b1, 1'b0, 1'b0});
  endtask

  task automatic push_frame(input int k, input logic [15:0] d, input logic par);
    logic [15:0] v;
    v = (INV_A[k] != 0) ? ~d : d;
    push_bit(k, 1'b0);
    for (int i = 0; i < 16; i++) push_bit(k, (LSB_A[k] != 0) ? v[i] : v[15-i]);
    if (PE_A[k] != 0) push_bit(k, par);
    push_bit(k, 1'b1);
    exp_q.push_back('{1'b1, 1'b0, 1'b1, 1'b1});
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic send(input int k, input logic [15:0] d, input logic par);
    @(negedge clk);
    chk("ready_before_accept", {31'd0, rdy[k]}, 1);
    din[k] = d;
    vin[k] = 1'b1;
    @(posedge clk);
    push_frame(k, d, par);
    @(negedge clk);
    vin[k] = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ser_out",  {31'd0, ser[cur]}, {31'd0, e.ser});
      chk("busy",     {31'd0, bsy[cur]}, {31'd0, e.busy});
      chk("done",     {31'd0, dn[cur]},  {31'd0, e.done});
      chk("in_ready", {31'd0, rdy[cur]}, {31'd0, e.rdy});
    end
  end

  initial begin
    vt[0] = '{0, 16'h00FF, 1'b0};
    vt[1] = '{0, 16'hA5C3, 1'b0};
    vt[2] = '{0, 16'h0007, 1'b1};
    vt[3] = '{1, 16'h0000, 1'b0};
    vt[4] = '{1, 16'h0001, 1'b1};
    vt[5] = '{2, 16'h8000, 1'b1};
    vt[6] = '{2, 16'h1234, 1'b1};
    vt[7] = '{3, 16'h0001, 1'b1};
    vt[8] = '{4, 16'h00F0, 1'b0};

    rst_n = 1'b1;
    for (int k = 0; k < N; k++) begin
      din[k] = '0;
      vin[k] = 1'b0;
    end
    #3 rst_n = 1'b0;
    #1;
    chk("rst_ser",   {31'd0, ser[0]}, 1);
    chk("rst_busy",  {31'd0, bsy[0]}, 0);
    chk("rst_done",  {31'd0, dn[0]},  0);
    chk("rst_ready", {31'd0, rdy[0]}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      cur = k;
      chk("rel_ready", {31'd0, rdy[k]}, 1);
      chk("rel_ser",   {31'd0, ser[k]}, 1);
      chk("rel_busy",  {31'd0, bsy[k]}, 0);
      chk("rel_done",  {31'd0, dn[k]},  0);
    end
    cur = 0;
    repeat (10) begin
      @(negedge clk);
      chk("idle_ser", {31'd0, ser[0]}, 1);
    end

    for (int i = 0; i < 9; i++) begin
      cur = vt[i].cfg;
      send(vt[i].cfg, vt[i].data, vt[i].par);
      drain(200);
    end

    // valid held across a frame; data changes mid-frame, next word taken 20 edges later
    cur = 0;
    @(negedge clk);
    chk("held_ready", {31'd0, rdy[0]}, 1);
    din[0] = 16'h0001;
    vin[0] = 1'b1;
    @(posedge clk);
    push_frame(0, 16'h0001, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      if (i == 20) push_frame(0, 16'hFFFF, 1'b0);
      else if (i == 5) begin
        @(negedge clk);
        din[0] = 16'hFFFF;
      end
    end
    @(negedge clk);
    vin[0] = 1'b0;
    drain(200);

    // reset during data bit 5
    cur = 0;
    @(negedge clk);
    din[0] = 16'h0020;
    vin[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vin[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("bit5_ser",  {31'd0, ser[0]}, 1);
    chk("bit5_busy", {31'd0, bsy[0]}, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ser",   {31'd0, ser[0]}, 1);
    chk("midrst_busy",  {31'd0, bsy[0]}, 0);
    chk("midrst_ready", {31'd0, rdy[0]}, 0);
    chk("midrst_done",  {31'd0, dn[0]},  0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("postrst_ready", {31'd0, rdy[0]}, 1);
    repeat (25) begin
      @(negedge clk);
      chk("postrst_done", {31'd0, dn[0]},  0);
      chk("postrst_ser",  {31'd0, ser[0]}, 1);
      chk("postrst_busy", {31'd0, bsy[0]}, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
